mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the clock port SHALL be named clk and the reset port rst, active-low.
REQ-002 The block SHALL have these parameters:
- WAIT_CYCLES, default 2: extra SRAM wait states per access (0..15).
- ADDR_W, default 32: address width.
- DATA_W, default 32: data width.
REQ-003 The block SHALL have these ports:
- clk  in  1  clock
- rst  in  1  async reset, active-low
- if_req  in  1  fetch read request (level)
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetch read data
- if_ready  out  1  fetch access complete, one-cycle pulse
- mem_req  in  1  data-stage request (level)
- mem_we  in  1  1=write, 0=read
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_rdata  out  DATA_W  load data
- mem_ready  out  1  data access complete, one-cycle pulse
- sram_cs  out  1  SRAM select
- sram_we  out  1  SRAM write enable
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data
- freeze  out  1  pipeline stall request

Function
REQ-004 The FSM SHALL have three states, IDLE, ACCESS and DONE:
- IDLE->ACCESS when if_req|mem_req.
- ACCESS->DONE after exactly WAIT_CYCLES+1 cycles in ACCESS.
- DONE->IDLE unconditionally.
REQ-005 On the IDLE->ACCESS edge the block SHALL latch the grant, the address, we (forced 0 for IF) and wdata; requester inputs SHALL be ignored until the next IDLE.
REQ-006 sram_cs SHALL be 1 only in ACCESS; sram_we/addr/wdata SHALL be driven from the latched values, and sram_we SHALL be 0 outside ACCESS.
REQ-007 A down-counter SHALL load WAIT_CYCLES on entry to ACCESS and decrement each ACCESS cycle; the FSM SHALL leave ACCESS when the counter is 0.
REQ-008 On the last ACCESS cycle the block SHALL capture sram_rdata into the granted requester's rdata register, for reads only.
REQ-009 In DONE the block SHALL assert the granted requester's ready for exactly one cycle; the rdata registers SHALL hold their values until overwritten.
REQ-010 With WAIT_CYCLES=W and a request seen in IDLE at cycle N, ready SHALL be high at cycle N+W+2, and the next grant SHALL be possible at N+W+3.
REQ-011 When both requests are seen in IDLE, the block SHALL grant MEM (fixed priority, unless REQ-016 applies).
REQ-012 If a requester drops req mid-access, the access SHALL complete and ready SHALL still pulse.
REQ-013 freeze SHALL equal (mem_req & ~mem_ready) | (if_req & ~if_ready), combinational.

Reset
REQ-014 On rst low, asynchronously:
- state SHALL be IDLE and the counter 0;
- sram_cs, sram_we, if_ready and mem_ready SHALL be 0;
- if_rdata, mem_rdata, sram_addr and sram_wdata SHALL be 0.
REQ-015 If reset asserts mid-ACCESS, the access SHALL be aborted with no ready pulse; after release the block SHALL start from IDLE.

Configuration
REQ-016 With MEM_ARB_ROUND_ROBIN_EN defined:
- a last_grant register (reset value IF) SHALL be kept;
- on simultaneous requests the block SHALL grant the requester not granted last.
REQ-017 Without MEM_ARB_ROUND_ROBIN_EN, the block SHALL use only the fixed MEM-over-IF priority, and no last_grant register SHALL exist.

Structure
REQ-018 Package mem_arb_pkg SHALL hold the state enum (ST_IDLE, ST_ACCESS, ST_DONE), the grant enum (GNT_IF, GNT_MEM) and the WAIT_CYCLES default constant.
REQ-019 The wait-state counter SHALL be one sub-module, arb_wait_cnt (load/decrement/zero flag); everything else SHALL be flat.

Verification
REQ-020 The bench SHALL use WAIT_CYCLES=2 and cover these scenarios:
- IF read, if_addr=0x10, SRAM returns 0xE3A01005 -> if_ready at N+4, if_rdata=0xE3A01005, sram_cs high for 3 cycles.
- MEM write, addr=0x400, wdata=0xDEADBEEF -> sram_we=1 for 3 cycles, mem_ready at N+4, mem_rdata unchanged.
- Both requesting at cycle N -> MEM served first (ready N+4), IF granted N+5 (ready N+9); with MEM_ARB_ROUND_ROBIN_EN a second conflict grants IF first.
- rst low in the 2nd ACCESS cycle -> sram_cs=0 immediately, no ready pulse, and a later IF request completes normally.
- mem_req held with mem_we=0 -> freeze=1 from N through N+3 and 0 in cycle N+4 (mem_ready high).
- WAIT_CYCLES=0 -> ready at N+2 and back-to-back IF requests completing every 3 cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data SRAM port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } grant_e;

    localparam int unsigned WAIT_CYCLES_DEF = 2;
    localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/arb_wait_cnt.sv
// Wait-state down-counter: load on access start, count down during the access, flag zero.
module arb_wait_cnt
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data-stage requesters onto one wait-stated SRAM port.
// Optional MEM_ARB_ROUND_ROBIN_EN replaces fixed MEM priority with alternating grants on conflict.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              sram_cs,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              freeze
);

    state_e            state_q, state_d;
    grant_e            gnt_q, gnt_sel;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q, mem_rdata_q;
    logic              start;
    logic              cnt_zero;
    logic              last_access;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    grant_e last_grant_q;

    always_comb begin
        gnt_sel = mem_req ? GNT_MEM : GNT_IF;
        if (if_req && mem_req) begin
            gnt_sel = (last_grant_q == GNT_IF) ? GNT_MEM : GNT_IF;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= GNT_IF;
        end else if (start) begin
            last_grant_q <= gnt_sel;
        end
    end
`else
    always_comb begin
        gnt_sel = mem_req ? GNT_MEM : GNT_IF;
    end
`endif

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (if_req || mem_req) begin
                    start   = 1'b1;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_zero) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    arb_wait_cnt u_wait_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (start),
        .dec_i      (state_q == ST_ACCESS),
        .load_val_i (CNT_W'(WAIT_CYCLES)),
        .zero_o     (cnt_zero)
    );

    assign last_access = (state_q == ST_ACCESS) && cnt_zero;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= GNT_IF;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            // Requester inputs are only sampled here; they are ignored until the next IDLE.
            if (start) begin
                gnt_q   <= gnt_sel;
                we_q    <= (gnt_sel == GNT_MEM) && mem_we;
                addr_q  <= (gnt_sel == GNT_MEM) ? mem_addr : if_addr;
                wdata_q <= (gnt_sel == GNT_MEM) ? mem_wdata : '0;
            end
            if (last_access && !we_q) begin
                if (gnt_q == GNT_MEM) begin
                    mem_rdata_q <= sram_rdata;
                end else begin
                    if_rdata_q  <= sram_rdata;
                end
            end
        end
    end

    assign sram_cs    = (state_q == ST_ACCESS);
    assign sram_we    = sram_cs && we_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign if_rdata   = if_rdata_q;
    assign mem_rdata  = mem_rdata_q;
    assign if_ready   = (state_q == ST_DONE) && (gnt_q == GNT_IF);
    assign mem_ready  = (state_q == ST_DONE) && (gnt_q == GNT_MEM);
    assign freeze     = (mem_req && !mem_ready) || (if_req && !if_ready);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    logic        if_req, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata, sram_rdata;
    logic [31:0] if_rdata, mem_rdata, sram_addr, sram_wdata;
    logic        if_ready, mem_ready, sram_cs, sram_we, freeze;

    logic        if_req_z, mem_req_z, mem_we_z;
    logic [31:0] if_addr_z, mem_addr_z, mem_wdata_z, sram_rdata_z;
    logic [31:0] if_rdata_z, mem_rdata_z, sram_addr_z, sram_wdata_z;
    logic        if_ready_z, mem_ready_z, sram_cs_z, sram_we_z, freeze_z;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WAIT_CYCLES(2), .ADDR_W(32), .DATA_W(32)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .freeze(freeze)
    );

    mem_port_arbiter #(.WAIT_CYCLES(0), .ADDR_W(32), .DATA_W(32)) u_dut_w0 (
        .clk(clk), .rst(rst),
        .if_req(if_req_z), .if_addr(if_addr_z), .if_rdata(if_rdata_z), .if_ready(if_ready_z),
        .mem_req(mem_req_z), .mem_we(mem_we_z), .mem_addr(mem_addr_z), .mem_wdata(mem_wdata_z),
        .mem_rdata(mem_rdata_z), .mem_ready(mem_ready_z),
        .sram_cs(sram_cs_z), .sram_we(sram_we_z), .sram_addr(sram_addr_z), .sram_wdata(sram_wdata_z),
        .sram_rdata(sram_rdata_z), .freeze(freeze_z)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // IF read with the request dropped (and address scrambled) after the grant edge.
    task automatic if_read(input logic [31:0] a, input logic [31:0] d);
        int cs_cnt;
        cs_cnt     = 0;
        if_req     = 1'b1;
        if_addr    = a;
        sram_rdata = d;
        for (int k = 0; k < 6; k++) begin
            if (k == 1) begin
                if_req  = 1'b0;
                if_addr = 32'hFFFF_FFF0;
            end
            if (k == 4) sram_rdata = 32'h0BAD_0BAD;
            sample();
            check("if_rd cs", sram_cs, (k >= 1 && k <= 3));
            check("if_rd ready", if_ready, (k == 4));
            check("if_rd mem_ready", mem_ready, 0);
            if (sram_cs) cs_cnt++;
            if (k == 0) check("if_rd freeze", freeze, 1);
            if (k >= 1 && k <= 3) begin
                check("if_rd addr", sram_addr, a);
                check("if_rd we", sram_we, 0);
            end
            if (k >= 4) check("if_rd rdata", if_rdata, d);
            next_cycle();
        end
        check("if_rd cs count", cs_cnt, 3);
    endtask

    initial begin
        rst = 1'b0;
        if_req = 0; mem_req = 0; mem_we = 0;
        if_addr = '0; mem_addr = '0; mem_wdata = '0; sram_rdata = '0;
        if_req_z = 0; mem_req_z = 0; mem_we_z = 0;
        if_addr_z = '0; mem_addr_z = '0; mem_wdata_z = '0; sram_rdata_z = '0;

        repeat (2) @(posedge clk);
        sample();
        check("rst cs", sram_cs, 0);
        check("rst we", sram_we, 0);
        check("rst if_ready", if_ready, 0);
        check("rst mem_ready", mem_ready, 0);
        check("rst if_rdata", if_rdata, 0);
        check("rst mem_rdata", mem_rdata, 0);
        check("rst addr", sram_addr, 0);
        check("rst wdata", sram_wdata, 0);
        check("rst freeze", freeze, 0);
        next_cycle();
        rst = 1'b1;
        next_cycle();

        // Plain IF read
        if_read(32'h10, 32'hE3A0_1005);

        // Reset asserted in the second ACCESS cycle aborts the access
        if_req = 1'b1; if_addr = 32'h50; sram_rdata = 32'h1111_2222;
        next_cycle();
        if_req = 1'b0;
        next_cycle();
        rst = 1'b0;
        #1;
        check("abort cs", sram_cs, 0);
        check("abort if_rdata", if_rdata, 0);
        check("abort addr", sram_addr, 0);
        next_cycle();
        rst = 1'b1;
        for (int k = 3; k < 8; k++) begin
            sample();
            check("abort no ready", if_ready, 0);
            check("abort no cs", sram_cs, 0);
            next_cycle();
        end
        if_read(32'h60, 32'hA5A5_0001);

        // Simultaneous requests: MEM first, IF granted on the next IDLE
        for (int k = 0; k < 11; k++) begin
            if (k == 0) begin
                if_req = 1'b1; if_addr = 32'h20;
                mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h404;
                sram_rdata = 32'hCAFE_0404;
            end
            if (k == 1) mem_req = 1'b0;
            if (k == 5) sram_rdata = 32'h1F1F_0020;
            if (k == 9) if_req = 1'b0;
            sample();
            check("both mem_ready", mem_ready, (k == 4));
            check("both if_ready", if_ready, (k == 9));
            check("both cs", sram_cs, ((k >= 1 && k <= 3) || (k >= 6 && k <= 8)));
            if (k == 1) check("both mem addr", sram_addr, 32'h404);
            if (k == 6) check("both if addr", sram_addr, 32'h20);
            if (k == 4) check("both mem_rdata", mem_rdata, 32'hCAFE_0404);
            if (k == 9) check("both if_rdata", if_rdata, 32'h1F1F_0020);
            next_cycle();
        end

        // MEM read held: freeze until the ready cycle
        for (int k = 0; k < 6; k++) begin
            if (k == 0) begin
                mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h408;
                sram_rdata = 32'h600D_F00D;
            end
            if (k == 5) mem_req = 1'b0;
            sample();
            check("frz freeze", freeze, (k <= 3));
            check("frz mem_ready", mem_ready, (k == 4));
            if (k == 4) check("frz mem_rdata", mem_rdata, 32'h600D_F00D);
            next_cycle();
        end

        // MEM write: sram_we for three cycles, mem_rdata untouched
        for (int k = 0; k < 6; k++) begin
            if (k == 0) begin
                mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h400;
                mem_wdata = 32'hDEAD_BEEF; sram_rdata = 32'h1234_5678;
            end
            if (k == 1) begin
                mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
            end
            sample();
            check("wr we", sram_we, (k >= 1 && k <= 3));
            check("wr mem_ready", mem_ready, (k == 4));
            if (k >= 1 && k <= 3) begin
                check("wr addr", sram_addr, 32'h400);
                check("wr wdata", sram_wdata, 32'hDEAD_BEEF);
            end
            if (k >= 4) check("wr mem_rdata", mem_rdata, 32'h600D_F00D);
            next_cycle();
        end

`ifdef MEM_ARB_ROUND_ROBIN_EN
        // Last grant was MEM, so this conflict goes to IF first
        for (int k = 0; k < 11; k++) begin
            if (k == 0) begin
                if_req = 1'b1; if_addr = 32'h30;
                mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h40C;
                sram_rdata = 32'h3030_3030;
            end
            if (k == 4) if_req = 1'b0;
            if (k == 5) sram_rdata = 32'h4040_4040;
            if (k == 9) mem_req = 1'b0;
            sample();
            check("rr if_ready", if_ready, (k == 4));
            check("rr mem_ready", mem_ready, (k == 9));
            if (k == 1) check("rr if addr", sram_addr, 32'h30);
            if (k == 6) check("rr mem addr", sram_addr, 32'h40C);
            if (k == 9) check("rr mem_rdata", mem_rdata, 32'h4040_4040);
            next_cycle();
        end
`endif

        // WAIT_CYCLES=0: back-to-back IF reads every three cycles
        for (int k = 0; k < 10; k++) begin
            if_req_z     = (k < 8);
            if_addr_z    = 32'h100 + 32'(k) * 4;
            sram_rdata_z = 32'h1000_0000 + 32'(k);
            sample();
            check("w0 ready", if_ready_z, (k == 2 || k == 5 || k == 8));
            check("w0 cs", sram_cs_z, (k == 1 || k == 4 || k == 7));
            if (k == 1 || k == 4 || k == 7) check("w0 addr", sram_addr_z, 32'h100 + 32'(k - 1) * 4);
            if (k == 2 || k == 5 || k == 8) check("w0 rdata", if_rdata_z, 32'h1000_0000 + 32'(k - 1));
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
